// File: rtl/ivs_axi_mem_slv_if.sv
// AXI3-style bus bundle between the IVS master port and the scratch-memory slave.
// Clock and reset stay outside the bundle as plain scalar ports.
interface ivs_axi_mem_slv_if #(
  parameter int IDW  = 6,
  parameter int LENW = 6
);
  logic            awvalid;
  logic            awready;
  logic [IDW-1:0]  awid;
  logic [63:0]     awaddr;
  logic [LENW-1:0] awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;

  logic            wvalid;
  logic            wready;
  logic [IDW-1:0]  wid;
  logic [127:0]    wdata;
  logic [15:0]     wstrb;
  logic            wlast;

  logic            bvalid;
  logic            bready;
  logic [IDW-1:0]  bid;
  logic [1:0]      bresp;

  logic            arvalid;
  logic            arready;
  logic [IDW-1:0]  arid;
  logic [63:0]     araddr;
  logic [LENW-1:0] arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;

  logic            rvalid;
  logic            rready;
  logic [IDW-1:0]  rid;
  logic [127:0]    rdata;
  logic [1:0]      rresp;
  logic            rlast;

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    input  wvalid, wid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst,
    input  rready,
    output awready, wready, bvalid, bid, bresp,
    output arready, rvalid, rid, rdata, rresp, rlast
  );

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    output wvalid, wid, wdata, wstrb, wlast,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst,
    output rready,
    input  awready, wready, bvalid, bid, bresp,
    input  arready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/ivs_axi_mem_slv.sv
// Single-outstanding AXI3-style slave backed by DEPTH x 128-bit single-port storage.
// One burst at a time; AW/AR arbitrated round-robin in IDLE with zero-wait accept.
module ivs_axi_mem_slv #(
  parameter int DEPTH = 1024,
  parameter int IDW   = 6,
  parameter int LENW  = 6
) (
  input  logic           i_aclk,
  input  logic           i_arst,
  ivs_axi_mem_slv_if.slave io_axi
);

  localparam int          AW          = $clog2(DEPTH);
  localparam logic [59:0] DEPTH_W     = 60'(DEPTH);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

  state_t         r_state;
  logic           r_prioRd;
  logic [IDW-1:0] r_id;
  logic [AW-1:0]  r_idx;
  logic [LENW:0]  r_len;
  logic [LENW:0]  r_cnt;
  logic           r_incr;
  logic [1:0]     r_resp;
  logic           r_wErr;
  logic           r_bvalid;
  logic [1:0]     r_bresp;
  logic           r_rvalid;
  logic           r_rlast;
  logic [1:0]     r_rresp;
  logic [127:0]   r_rdata;
  logic [127:0]   r_mem [DEPTH];

  logic           w_idle;
  logic           w_grantW;
  logic           w_grantR;
  logic           w_wBeat;
  logic           w_wInRange;
  logic           w_wIdOk;
  logic           w_beatErr;
  logic           w_memWe;
  logic [1:0]     w_bresp;
  logic [AW-1:0]  w_idxNext;
  logic           w_rdIssue;
  logic           w_rHs;

  // DECERR outranks SLVERR; only full-width INCR/FIXED bursts are legal.
  function automatic logic [1:0] f_resp(input logic [63:0] addr, input logic [2:0] size,
                                        input logic [1:0] burst);
    if (addr[63:4] >= DEPTH_W) return RESP_DECERR;
    if (size != 3'b100 || burst[1]) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  assign w_idle     = (r_state == IDLE) && !i_arst;
  assign w_grantW   = w_idle && io_axi.awvalid && (!io_axi.arvalid || !r_prioRd);
  assign w_grantR   = w_idle && io_axi.arvalid && !w_grantW;
  assign w_wBeat    = (r_state == WR_DATA) && io_axi.wvalid;
  assign w_wInRange = (r_cnt <= r_len);
  assign w_wIdOk    = (io_axi.wid == r_id);
  assign w_beatErr  = !w_wIdOk || (io_axi.wlast != (r_cnt == r_len));
  assign w_memWe    = w_wBeat && w_wInRange && w_wIdOk && (r_resp == RESP_OKAY);
  assign w_bresp    = (r_resp == RESP_DECERR) ? RESP_DECERR :
                      ((r_resp == RESP_SLVERR) || r_wErr || w_beatErr) ? RESP_SLVERR : RESP_OKAY;
  assign w_idxNext  = r_incr ? r_idx + AW'(1) : r_idx;
  // Next beat is fetched whenever the output slot is empty or being drained.
  assign w_rdIssue  = (r_state == RD_DATA) && (r_cnt <= r_len) && (!r_rvalid || io_axi.rready);
  assign w_rHs      = r_rvalid && io_axi.rready;

  assign io_axi.awready = w_grantW;
  assign io_axi.arready = w_grantR;
  assign io_axi.wready  = (r_state == WR_DATA);
  assign io_axi.bvalid  = r_bvalid;
  assign io_axi.bid     = r_id;
  assign io_axi.bresp   = r_bresp;
  assign io_axi.rvalid  = r_rvalid;
  assign io_axi.rid     = r_id;
  assign io_axi.rdata   = r_rdata;
  assign io_axi.rresp   = r_rresp;
  assign io_axi.rlast   = r_rlast;

  always_ff @(posedge i_aclk or posedge i_arst) begin
    if (i_arst) begin
      r_state  <= IDLE;
      r_prioRd <= 1'b0;
      r_id     <= '0;
      r_idx    <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_incr   <= 1'b0;
      r_resp   <= RESP_OKAY;
      r_wErr   <= 1'b0;
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantW) begin
            r_state  <= WR_DATA;
            r_prioRd <= 1'b1;
            r_id     <= io_axi.awid;
            r_idx    <= io_axi.awaddr[4 +: AW];
            r_len    <= {1'b0, io_axi.awlen};
            r_incr   <= (io_axi.awburst == 2'b01);
            r_resp   <= f_resp(io_axi.awaddr, io_axi.awsize, io_axi.awburst);
            r_cnt    <= '0;
            r_wErr   <= 1'b0;
          end else if (w_grantR) begin
            r_state  <= RD_DATA;
            r_prioRd <= 1'b0;
            r_id     <= io_axi.arid;
            r_idx    <= io_axi.araddr[4 +: AW];
            r_len    <= {1'b0, io_axi.arlen};
            r_incr   <= (io_axi.arburst == 2'b01);
            r_resp   <= f_resp(io_axi.araddr, io_axi.arsize, io_axi.arburst);
            r_cnt    <= '0;
          end
        end
        WR_DATA: begin
          if (w_wBeat) begin
            // Overrun beats past awlen are swallowed without advancing the counter.
            if (w_wInRange) begin
              r_cnt <= r_cnt + 1'b1;
              r_idx <= w_idxNext;
            end
            if (w_beatErr) r_wErr <= 1'b1;
            if (io_axi.wlast) begin
              r_state  <= WR_RESP;
              r_bvalid <= 1'b1;
              r_bresp  <= w_bresp;
            end
          end
        end
        WR_RESP: begin
          if (io_axi.bready) begin
            r_bvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        RD_DATA: begin
          if (w_rdIssue) begin
            r_rvalid <= 1'b1;
            r_rlast  <= (r_cnt == r_len);
            r_rresp  <= r_resp;
            r_rdata  <= (r_resp == RESP_OKAY) ? r_mem[r_idx] : '0;
            r_cnt    <= r_cnt + 1'b1;
            r_idx    <= w_idxNext;
          end else if (w_rHs) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            if (r_rlast) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset so contents survive a mid-burst reset.
  always_ff @(posedge i_aclk) begin
    if (w_memWe) begin
      for (int b = 0; b < 16; b++) begin
        if (io_axi.wstrb[b]) r_mem[r_idx][8*b +: 8] <= io_axi.wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ivs_axi_mem_slv.sv
// Directed bench for ivs_axi_mem_slv: each scenario task drives the bus and
// compares observed responses against hand-derived expectations.
module tb_ivs_axi_mem_slv;

  localparam int DEPTH = 64;

  logic clk;
  logic arst;
  int   nChecks;
  int   nPass;

  logic [127:0] wD [64];
  logic [15:0]  wS [64];
  logic [127:0] rD [64];
  logic [1:0]   rR [64];
  logic         rL [64];
  logic [5:0]   rI [64];

  ivs_axi_mem_slv_if #(.IDW(6), .LENW(6)) axi ();

  ivs_axi_mem_slv #(.DEPTH(DEPTH), .IDW(6), .LENW(6)) dut (
    .i_aclk (clk),
    .i_arst (arst),
    .io_axi (axi)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [127:0] mkData(input int seed, input int i);
    return {32'(seed), 32'hA5A5_0000 + 32'(i), 32'(seed * 16 + i), ~32'(seed ^ i)};
  endfunction

  // Bus driver: AW handshake, nBeats W beats (wlast on the final one), then B.
  task automatic axiWrite(input logic [5:0] id, input logic [63:0] addr, input logic [5:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nBeats,
                          output logic [1:0] resp, output logic [5:0] bidO, output int bLat);
    int n;
    bit ok;
    axi.awvalid = 1'b1; axi.awid = id; axi.awaddr = addr; axi.awlen = len;
    axi.awsize = size; axi.awburst = burst; axi.bready = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 40) begin @(negedge clk); ok = axi.awready; @(posedge clk); #1; n++; end
    axi.awvalid = 1'b0;
    if (!ok) begin nChecks++; $display("[TB] FAIL aw_timeout: awready never rose"); end
    for (int i = 0; i < nBeats && ok; i++) begin
      axi.wvalid = 1'b1; axi.wid = id; axi.wdata = wD[i]; axi.wstrb = wS[i];
      axi.wlast = (i == nBeats - 1);
      n = 0; ok = 1'b0;
      while (!ok && n < 40) begin @(negedge clk); ok = axi.wready; @(posedge clk); #1; n++; end
      if (!ok) begin nChecks++; $display("[TB] FAIL w_timeout: wready low at beat %0d", i); end
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    bLat = 0; ok = 1'b0;
    while (!ok && bLat < 40) begin @(negedge clk); bLat++; ok = axi.bvalid; end
    if (!ok) begin nChecks++; $display("[TB] FAIL b_timeout: bvalid never rose"); end
    resp = axi.bresp; bidO = axi.bid;
    @(posedge clk); #1;
  endtask

  // Bus driver: AR handshake then collect beats with rready following pat (LSB first).
  task automatic axiRead(input logic [5:0] id, input logic [63:0] addr, input logic [5:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [7:0] pat, input int patLen,
                         output int nb, output int firstLat, output int lastCyc, output int unstable);
    int n, k;
    bit ok, done, stall;
    logic [127:0] pD;
    logic [1:0]   pR;
    logic         pL;
    logic [5:0]   pI;
    axi.arvalid = 1'b1; axi.arid = id; axi.araddr = addr; axi.arlen = len;
    axi.arsize = size; axi.arburst = burst;
    n = 0; ok = 1'b0;
    while (!ok && n < 40) begin @(negedge clk); ok = axi.arready; @(posedge clk); #1; n++; end
    axi.arvalid = 1'b0;
    if (!ok) begin nChecks++; $display("[TB] FAIL ar_timeout: arready never rose"); end
    k = 0; axi.rready = pat[0];
    nb = 0; firstLat = -1; lastCyc = -1; unstable = 0;
    stall = 1'b0; done = !ok;
    pD = '0; pR = '0; pL = 1'b0; pI = '0;
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      @(negedge clk);
      if (axi.rvalid && firstLat < 0) firstLat = cyc;
      if (stall && (!axi.rvalid || axi.rdata !== pD || axi.rresp !== pR ||
                    axi.rlast !== pL || axi.rid !== pI)) unstable++;
      stall = 1'b0;
      if (axi.rvalid && axi.rready) begin
        rD[nb] = axi.rdata; rR[nb] = axi.rresp; rL[nb] = axi.rlast; rI[nb] = axi.rid;
        nb++; lastCyc = cyc;
        if (axi.rlast || nb == 64) done = 1'b1;
      end else if (axi.rvalid) begin
        stall = 1'b1; pD = axi.rdata; pR = axi.rresp; pL = axi.rlast; pI = axi.rid;
      end
      @(posedge clk); #1;
      k++;
      axi.rready = done ? 1'b0 : pat[k % patLen];
    end
    axi.rready = 1'b0;
    if (!done) begin nChecks++; $display("[TB] FAIL r_timeout: rlast never handshaken"); end
  endtask

  task automatic test_reset();
    arst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nChecks++;
    if ({axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid, axi.rlast} !== 6'b0)
      $display("[TB] FAIL reset_valids: got %b expected 000000",
               {axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid, axi.rlast});
    else nPass++;
    nChecks++;
    if ({axi.rdata, axi.rresp, axi.bresp, axi.bid, axi.rid} !== '0)
      $display("[TB] FAIL reset_data: got %h expected 0",
               {axi.rdata, axi.rresp, axi.bresp, axi.bid, axi.rid});
    else nPass++;
    @(posedge clk); #1;
    arst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_arbitration();
    int arBad, awBad;
    bit got;
    logic [127:0] rd;
    logic         rl;
    logic [1:0]   resp;
    logic [5:0]   bidO;
    int           bLat;
    axi.awvalid = 1'b1; axi.awid = 6'h11; axi.awaddr = 64'h200; axi.awlen = 6'd0;
    axi.awsize = 3'b100; axi.awburst = 2'b01;
    axi.arvalid = 1'b1; axi.arid = 6'h22; axi.araddr = 64'h200; axi.arlen = 6'd0;
    axi.arsize = 3'b100; axi.arburst = 2'b01;
    @(negedge clk);
    nChecks++; if (axi.awready !== 1'b1) $display("[TB] FAIL tie1_awready: got %b expected 1", axi.awready); else nPass++;
    nChecks++; if (axi.arready !== 1'b0) $display("[TB] FAIL tie1_arready: got %b expected 0", axi.arready); else nPass++;
    @(posedge clk); #1;
    axi.awvalid = 1'b0;
    axi.wvalid = 1'b1; axi.wid = 6'h11; axi.wdata = mkData(3, 0); axi.wstrb = 16'hFFFF; axi.wlast = 1'b1;
    arBad = 0;
    @(negedge clk); if (axi.arready) arBad++;
    @(posedge clk); #1;
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    @(negedge clk); if (axi.arready) arBad++;
    nChecks++; if (axi.bvalid !== 1'b1) $display("[TB] FAIL tie1_bvalid: got %b expected 1", axi.bvalid); else nPass++;
    @(posedge clk); #1;
    axi.awvalid = 1'b1; axi.awid = 6'h33; axi.awaddr = 64'h210;
    @(negedge clk);
    nChecks++; if (arBad !== 0) $display("[TB] FAIL tie1_ar_held_low: got %0d high cycles expected 0", arBad); else nPass++;
    nChecks++; if (axi.arready !== 1'b1) $display("[TB] FAIL tie2_arready: got %b expected 1", axi.arready); else nPass++;
    nChecks++; if (axi.awready !== 1'b0) $display("[TB] FAIL tie2_awready: got %b expected 0", axi.awready); else nPass++;
    @(posedge clk); #1;
    axi.arvalid = 1'b0; axi.rready = 1'b1;
    awBad = 0; got = 1'b0; rd = '0; rl = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (axi.awready) awBad++;
      if (axi.rvalid) begin got = 1'b1; rd = axi.rdata; rl = axi.rlast; end
      @(posedge clk); #1;
    end
    axi.rready = 1'b0;
    nChecks++; if (awBad !== 0) $display("[TB] FAIL tie2_aw_held_low: got %0d high cycles expected 0", awBad); else nPass++;
    nChecks++; if (rd !== mkData(3, 0)) $display("[TB] FAIL tie2_rdata: got %h expected %h", rd, mkData(3, 0)); else nPass++;
    nChecks++; if (rl !== 1'b1) $display("[TB] FAIL tie2_rlast: got %b expected 1", rl); else nPass++;
    wD[0] = mkData(4, 0); wS[0] = 16'hFFFF;
    axiWrite(6'h33, 64'h210, 6'd0, 3'b100, 2'b01, 1, resp, bidO, bLat);
    nChecks++; if (bidO !== 6'h33) $display("[TB] FAIL tie2_write_bid: got %h expected 33", bidO); else nPass++;
    nChecks++; if (resp !== 2'b00) $display("[TB] FAIL tie2_write_bresp: got %b expected 00", resp); else nPass++;
  endtask

  task automatic test_incr_write_read();
    logic [1:0] resp;
    logic [5:0] bidO;
    int bLat, nb, firstLat, lastCyc, unstable;
    for (int i = 0; i < 4; i++) begin wD[i] = mkData(1, i); wS[i] = 16'hFFFF; end
    axiWrite(6'h05, 64'h100, 6'd3, 3'b100, 2'b01, 4, resp, bidO, bLat);
    nChecks++; if (resp !== 2'b00) $display("[TB] FAIL t1_bresp: got %b expected 00", resp); else nPass++;
    nChecks++; if (bidO !== 6'h05) $display("[TB] FAIL t1_bid: got %h expected 05", bidO); else nPass++;
    nChecks++; if (bLat !== 1) $display("[TB] FAIL t1_b_latency: got %0d expected 1", bLat); else nPass++;
    axiRead(6'h09, 64'h100, 6'd3, 3'b100, 2'b01, 8'h01, 1, nb, firstLat, lastCyc, unstable);
    nChecks++; if (nb !== 4) $display("[TB] FAIL t1_beats: got %0d expected 4", nb); else nPass++;
    nChecks++; if (firstLat !== 2) $display("[TB] FAIL t1_r_latency: got %0d expected 2", firstLat); else nPass++;
    nChecks++; if (lastCyc - firstLat !== 3) $display("[TB] FAIL t1_no_bubbles: got span %0d expected 3", lastCyc - firstLat); else nPass++;
    for (int i = 0; i < 4; i++) begin
      nChecks++; if (rD[i] !== mkData(1, i)) $display("[TB] FAIL t1_rdata%0d: got %h expected %h", i, rD[i], mkData(1, i)); else nPass++;
      nChecks++; if (rL[i] !== (i == 3)) $display("[TB] FAIL t1_rlast%0d: got %b expected %b", i, rL[i], (i == 3)); else nPass++;
    end
    nChecks++; if ({rR[0], rR[3]} !== 4'b0) $display("[TB] FAIL t1_rresp: got %b expected 0000", {rR[0], rR[3]}); else nPass++;
    nChecks++; if (rI[0] !== 6'h09) $display("[TB] FAIL t1_rid: got %h expected 09", rI[0]); else nPass++;
    @(negedge clk);
    nChecks++; if (axi.rvalid !== 1'b0) $display("[TB] FAIL t1_rvalid_after: got %b expected 0", axi.rvalid); else nPass++;
    @(posedge clk); #1;
  endtask

  task automatic test_strobe();
    logic [1:0] resp;
    logic [5:0] bidO;
    int bLat, nb, firstLat, lastCyc, unstable;
    wD[0] = '1; wS[0] = 16'hFFFF;
    axiWrite(6'h01, 64'h0, 6'd0, 3'b100, 2'b01, 1, resp, bidO, bLat);
    wD[0] = '0; wS[0] = 16'h000F;
    axiWrite(6'h01, 64'h0, 6'd0, 3'b100, 2'b01, 1, resp, bidO, bLat);
    axiRead(6'h02, 64'h0, 6'd0, 3'b100, 2'b01, 8'h01, 1, nb, firstLat, lastCyc, unstable);
    nChecks++;
    if (rD[0] !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000)
      $display("[TB] FAIL t2_strobe: got %h expected ffffffffffffffffffffffff00000000", rD[0]);
    else nPass++;
  endtask

  task automatic test_errors();
    logic [1:0] resp;
    logic [5:0] bidO;
    int bLat, nb, firstLat, lastCyc, unstable;
    axiRead(6'h0A, 64'(DEPTH * 16), 6'd1, 3'b100, 2'b01, 8'h01, 1, nb, firstLat, lastCyc, unstable);
    nChecks++; if (nb !== 2) $display("[TB] FAIL t4_decerr_beats: got %0d expected 2", nb); else nPass++;
    nChecks++; if ({rR[0], rR[1]} !== 4'b1111) $display("[TB] FAIL t4_decerr_rresp: got %b expected 1111", {rR[0], rR[1]}); else nPass++;
    nChecks++; if ({rD[0], rD[1]} !== 256'b0) $display("[TB] FAIL t4_decerr_rdata: got %h expected 0", {rD[0], rD[1]}); else nPass++;
    nChecks++; if ({rL[0], rL[1]} !== 2'b01) $display("[TB] FAIL t4_decerr_rlast: got %b expected 01", {rL[0], rL[1]}); else nPass++;
    wD[0] = mkData(9, 9); wS[0] = 16'hFFFF;
    axiWrite(6'h0B, 64'h100, 6'd0, 3'b010, 2'b01, 1, resp, bidO, bLat);
    nChecks++; if (resp !== 2'b10) $display("[TB] FAIL t4_size_bresp: got %b expected 10", resp); else nPass++;
    axiRead(6'h0C, 64'h100, 6'd0, 3'b100, 2'b01, 8'h01, 1, nb, firstLat, lastCyc, unstable);
    nChecks++; if (rD[0] !== mkData(1, 0)) $display("[TB] FAIL t4_mem_unchanged: got %h expected %h", rD[0], mkData(1, 0)); else nPass++;
  endtask

  task automatic test_backpressure();
    logic [1:0] resp;
    logic [5:0] bidO;
    int bLat, nb, firstLat, lastCyc, unstable, lastCount;
    for (int i = 0; i < 8; i++) begin wD[i] = mkData(5, i); wS[i] = 16'hFFFF; end
    axiWrite(6'h15, 64'h300, 6'd7, 3'b100, 2'b01, 8, resp, bidO, bLat);
    axiRead(6'h16, 64'h300, 6'd7, 3'b100, 2'b01, 8'b0000_1001, 4, nb, firstLat, lastCyc, unstable);
    nChecks++; if (nb !== 8) $display("[TB] FAIL t5_beats: got %0d expected 8", nb); else nPass++;
    nChecks++; if (unstable !== 0) $display("[TB] FAIL t5_stall_stable: got %0d changes expected 0", unstable); else nPass++;
    lastCount = 0;
    for (int i = 0; i < 8; i++) begin
      if (rL[i]) lastCount++;
      nChecks++; if (rD[i] !== mkData(5, i)) $display("[TB] FAIL t5_rdata%0d: got %h expected %h", i, rD[i], mkData(5, i)); else nPass++;
    end
    nChecks++; if (lastCount !== 1 || rL[7] !== 1'b1) $display("[TB] FAIL t5_rlast: got count %0d last %b expected 1 1", lastCount, rL[7]); else nPass++;
    for (int i = 0; i < 2; i++) begin wD[i] = mkData(7, i); wS[i] = 16'hFFFF; end
    axiWrite(6'h17, 64'h380, 6'd3, 3'b100, 2'b01, 2, resp, bidO, bLat);
    nChecks++; if (resp !== 2'b10) $display("[TB] FAIL t5_early_wlast: got %b expected 10", resp); else nPass++;
  endtask

  task automatic test_fixed();
    logic [1:0] resp;
    logic [5:0] bidO;
    int bLat, nb, firstLat, lastCyc, unstable;
    for (int i = 0; i < 2; i++) begin wD[i] = mkData(6, i); wS[i] = 16'hFFFF; end
    axiWrite(6'h18, 64'h3C0, 6'd1, 3'b100, 2'b00, 2, resp, bidO, bLat);
    nChecks++; if (resp !== 2'b00) $display("[TB] FAIL fixed_bresp: got %b expected 00", resp); else nPass++;
    axiRead(6'h19, 64'h3C0, 6'd0, 3'b100, 2'b01, 8'h01, 1, nb, firstLat, lastCyc, unstable);
    nChecks++; if (rD[0] !== mkData(6, 1)) $display("[TB] FAIL fixed_rdata: got %h expected %h", rD[0], mkData(6, 1)); else nPass++;
  endtask

  task automatic test_reset_midburst();
    int n, nb, firstLat, lastCyc, unstable;
    bit got;
    axi.arvalid = 1'b1; axi.arid = 6'h07; axi.araddr = 64'h100; axi.arlen = 6'd3;
    axi.arsize = 3'b100; axi.arburst = 2'b01;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin @(negedge clk); got = axi.arready; @(posedge clk); #1; n++; end
    axi.arvalid = 1'b0; axi.rready = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 10) begin @(negedge clk); got = axi.rvalid; @(posedge clk); #1; n++; end
    nChecks++; if (got !== 1'b1) $display("[TB] FAIL t6_first_beat: got rvalid %b expected 1", got); else nPass++;
    arst = 1'b1;
    @(negedge clk);
    nChecks++; if (axi.rvalid !== 1'b0) $display("[TB] FAIL t6_rvalid_reset: got %b expected 0", axi.rvalid); else nPass++;
    @(posedge clk); #1;
    arst = 1'b0; axi.rready = 1'b0;
    axiRead(6'h08, 64'h100, 6'd3, 3'b100, 2'b01, 8'h01, 1, nb, firstLat, lastCyc, unstable);
    nChecks++; if (nb !== 4) $display("[TB] FAIL t6_after_beats: got %0d expected 4", nb); else nPass++;
    nChecks++; if (firstLat !== 2) $display("[TB] FAIL t6_after_latency: got %0d expected 2", firstLat); else nPass++;
    nChecks++; if (rD[3] !== mkData(1, 3)) $display("[TB] FAIL t6_after_rdata: got %h expected %h", rD[3], mkData(1, 3)); else nPass++;
  endtask

  initial begin
    clk = 1'b0; arst = 1'b1; nChecks = 0; nPass = 0;
    axi.awvalid = 1'b0; axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
    axi.wvalid = 1'b0; axi.wid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
    axi.bready = 1'b1;
    axi.arvalid = 1'b0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
    axi.rready = 1'b0;
    test_reset();
    test_arbitration();
    test_incr_write_read();
    test_strobe();
    test_errors();
    test_backpressure();
    test_fixed();
    test_reset_midburst();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/ivs_axi_mem_slv.md
Name: ivs_axi_mem_slv

Overview:
- Synthesizable AXI3-style slave memory: the responder at the far end of the AXI master port of the IVS top.
- Accepts one read or write burst at a time and services it from internal single-port storage (DEPTH x 128 bit).
- Returns R beats and B responses on the standard AXI handshakes.
- Used as on-chip scratch memory and as the reference responder in system benches.

Parameters:
DEPTH, 1024, number of 128-bit words; power of two, >= 2
IDW, 6, width of all ID fields
LENW, 6, width of awlen/arlen; burst beats = len+1 (1..64)

Ports:
aclk  in  1  clock
arst  in  1  asynchronous reset, active-high
awvalid in 1 / awready out 1  write address handshake
awid in IDW / awaddr in 64 / awlen in LENW / awsize in 3 / awburst in 2  write address attributes
wvalid in 1 / wready out 1 / wid in IDW / wdata in 128 / wstrb in 16 / wlast in 1  write data channel
bvalid out 1 / bready in 1 / bid out IDW / bresp out 2  write response channel
arvalid in 1 / arready out 1 / arid in IDW / araddr in 64 / arlen in LENW / arsize in 3 / arburst in 2  read address channel
rvalid out 1 / rready in 1 / rid out IDW / rdata out 128 / rresp out 2 / rlast out 1  read data channel

Behaviour:
- Reset: all outputs 0. State IDLE. Round-robin pointer selects write first. Memory contents are not reset.
- Word index: addr[4 +: log2(DEPTH)]. addr[3:0] is ignored.
- Range check: start addr[63:4] >= DEPTH gives DECERR (2'b11) for the whole burst.
- Burst type:
  - INCR (01): index +1 per beat, wrapping modulo DEPTH.
  - FIXED (00): index is held for every beat.
  - WRAP or reserved: SLVERR (2'b10).
- Size: any size other than 3'b100 gives SLVERR.
- Error handling: errored bursts still complete their full handshake. Writes are discarded; reads return rdata = 0.
- Response priority: DECERR takes precedence over SLVERR. Otherwise OKAY (00).
- FSM states: IDLE, WR_DATA, WR_RESP, RD_DATA.
- IDLE:
  - awready = arready = 0 until the arbiter decides. Decision is combinational in IDLE: the valid request wins.
  - On a tie, the channel not granted last time wins.
  - The granted ready is asserted in the same cycle (zero-wait accept).
  - Attributes are latched and the pointer updated.
  - Next state: WR_DATA or RD_DATA.
- WR_DATA:
  - wready = 1. Each wvalid&wready beat writes wdata using wstrb byte enables (bit i covers byte i) at the current index.
  - wid != latched awid: the beat is not written and the burst is flagged SLVERR.
  - wlast on beat count == awlen: go to WR_RESP.
  - Early wlast: go to WR_RESP with SLVERR.
  - Missing wlast at beat awlen: further beats are accepted but discarded until wlast, with SLVERR.
  - W beats are never accepted outside WR_DATA.
- WR_RESP:
  - bvalid = 1, bid = latched awid, bresp as accumulated.
  - Held stable until bready, then IDLE.
  - bvalid rises the cycle after the wlast handshake.
- RD_DATA:
  - Synchronous memory read; first rvalid is 2 cycles after the AR handshake cycle.
  - rid = latched arid. rlast = 1 on beat arlen only.
  - rvalid/rdata/rresp/rlast are held stable while rready = 0.
  - Prefetch guarantees one beat per cycle when rready is held at 1 (no bubbles).
  - After the rlast handshake: IDLE on the next cycle.
- Single outstanding transaction total; the other channel waits (ready low).
- Reset mid-burst: immediate return to IDLE with all valids low. The partial write is left in memory.

Test Plan:
1. Write INCR awaddr=0x100, awlen=3, wstrb=FFFF, data D0..D3, bready=1 -> bvalid 1 cycle after wlast, bid=awid, bresp=00. Read back same addr, arlen=3, rready=1 -> rvalid at T+2, D0..D3 on 4 consecutive cycles, rlast on 4th, rresp=00.
2. Partial strobe: write 0x0 with all-ones, then wstrb=0x000F with data 0 -> read gives bytes 3:0 = 0, bytes 15:4 = FF.
3. awvalid and arvalid asserted together from reset -> write granted first. Repeat the tie -> read granted. Loser's ready stays 0 until IDLE.
4. araddr = DEPTH*16, arlen=1 -> 2 beats, rresp=11, rdata=0, rlast on beat 2. awsize=3'b010 -> bresp=10, memory unchanged.
5. Read arlen=7 with rready toggled 1,0,0,1,… -> each beat held stable while stalled; 8 beats in order, no loss or duplication. Early wlast on beat 2 of awlen=3 -> bresp=10.
6. Assert arst during beat 2 of a read -> next cycle rvalid=0, state IDLE; a following transaction completes normally.
